// File: rtl/mul8_seq_ctrl.sv
// rtl/mul8_seq_ctrl.sv - 8x8 multiplier controller sharing one 4x4 sub-multiplier port
// Walks LL/LH/HL/HH nibble pairs and shift-accumulates the returned sub-products.
module mul8_seq_ctrl #(
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [7:0]  i_a,
    input  logic [7:0]  i_b,
    output logic [3:0]  o_sub_a,
    output logic [3:0]  o_sub_b,
    output logic [1:0]  o_sub_sel,
    input  logic [7:0]  i_sub_prod,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [15:0] o_prod,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [15:0] r_acc;
    logic [15:0] r_prod;
    logic [1:0]  r_step;
    logic [2:0]  w_first;
    logic [2:0]  w_next;
    logic [15:0] w_term;
    logic [15:0] w_sum;
    logic        w_calc;

    function automatic logic [3:0] f_nib(input logic [7:0] v, input logic hi);
        return hi ? v[7:4] : v[3:0];
    endfunction

    // Returns {found, step}: the lowest step >= start whose nibble pair must be issued.
    function automatic logic [2:0] f_next_step(input logic [7:0] a, input logic [7:0] b,
                                               input logic [2:0] start);
        logic [2:0] res;
        logic       live;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            live = !SKIP_ZERO || ((f_nib(a, k[1]) != 4'h0) && (f_nib(b, k[0]) != 4'h0));
            if ((3'(k) >= start) && live) begin
                res = {1'b1, 2'(k)};
            end
        end
        return res;
    endfunction

    assign w_first = f_next_step(i_a, i_b, 3'd0);
    assign w_next  = f_next_step(r_a, r_b, {1'b0, r_step} + 3'd1);
    assign w_calc  = (r_state == ST_CALC);

    always_comb begin
        w_term = 16'h0000;
        case (r_step)
            2'd0:    w_term = {8'h00, i_sub_prod};
            2'd1,
            2'd2:    w_term = {4'h0, i_sub_prod, 4'h0};
            default: w_term = {i_sub_prod, 8'h00};
        endcase
    end

    // Sum wraps modulo 2^16; approximate units may overshoot the exact product.
    assign w_sum = r_acc + w_term;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        o_busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    w_state_nxt = w_first[2] ? ST_CALC : ST_DONE;
                end
            end
            ST_CALC: begin
                o_busy = 1'b1;
                if (!w_next[2]) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                o_busy      = 1'b1;
                o_out_valid = 1'b1;
                if (i_out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a    <= 8'h00;
            r_b    <= 8'h00;
            r_acc  <= 16'h0000;
            r_prod <= 16'h0000;
            r_step <= 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_in_valid) begin
                        r_a    <= i_a;
                        r_b    <= i_b;
                        r_acc  <= 16'h0000;
                        r_step <= w_first[1:0];
                        if (!w_first[2]) begin
                            r_prod <= 16'h0000;
                        end
                    end
                end
                ST_CALC: begin
                    r_acc <= w_sum;
                    if (w_next[2]) begin
                        r_step <= w_next[1:0];
                    end else begin
                        r_prod <= w_sum;
                        r_step <= 2'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Nibble outputs decode purely from registers, so they only move on clock edges.
    assign o_sub_a   = w_calc ? f_nib(r_a, r_step[1]) : 4'h0;
    assign o_sub_b   = w_calc ? f_nib(r_b, r_step[0]) : 4'h0;
    assign o_sub_sel = w_calc ? r_step : 2'd0;
    assign o_prod    = r_prod;

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// tb/tb_mul8_seq_ctrl.sv - directed and random checks of mul8_seq_ctrl against an arithmetic model
module tb_mul8_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  ina, inb;
    logic        iv0, iv1, ordy0, ordy1;
    logic        rdy0, rdy1, ov0, ov1, busy0, busy1;
    logic [3:0]  sa0, sb0, sa1, sb1;
    logic [1:0]  ss0, ss1;
    logic [7:0]  sp0, sp1;
    logic [15:0] p0, p1;
    logic        force_ff;
    logic        dsel;
    logic        m_rdy, m_ov, m_busy;
    logic [3:0]  m_sa, m_sb;
    logic [1:0]  m_ss;
    logic [15:0] m_p;
    logic [7:0]  ra, rb;
    logic [15:0] q[$];
    logic [15:0] expq;
    int          checks = 0;
    int          errors = 0;
    int          n, nres, cyc, last;
    logic        acc_now;

    always #5 clk = ~clk;

    assign sp0 = force_ff ? 8'hFF : {4'h0, sa0} * {4'h0, sb0};
    assign sp1 = {4'h0, sa1} * {4'h0, sb1};

    assign m_rdy  = dsel ? rdy1  : rdy0;
    assign m_ov   = dsel ? ov1   : ov0;
    assign m_busy = dsel ? busy1 : busy0;
    assign m_sa   = dsel ? sa1   : sa0;
    assign m_sb   = dsel ? sb1   : sb0;
    assign m_ss   = dsel ? ss1   : ss0;
    assign m_p    = dsel ? p1    : p0;

    mul8_seq_ctrl #(.SKIP_ZERO(1'b0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(iv0), .o_in_ready(rdy0),
        .i_a(ina), .i_b(inb), .o_sub_a(sa0), .o_sub_b(sb0), .o_sub_sel(ss0),
        .i_sub_prod(sp0), .o_out_valid(ov0), .i_out_ready(ordy0), .o_prod(p0), .o_busy(busy0)
    );

    mul8_seq_ctrl #(.SKIP_ZERO(1'b1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(iv1), .o_in_ready(rdy1),
        .i_a(ina), .i_b(inb), .o_sub_a(sa1), .o_sub_b(sb1), .o_sub_sel(ss1),
        .i_sub_prod(sp1), .o_out_valid(ov1), .i_out_ready(ordy1), .o_prod(p1), .o_busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_iv(input logic v);
        if (dsel) iv1 = v;
        else      iv0 = v;
    endtask

    task automatic set_ordy(input logic v);
        if (dsel) ordy1 = v;
        else      ordy0 = v;
    endtask

    // Issues one request and follows it through every issued step up to the first DONE cycle.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b);
        logic [1:0]  steps[$];
        logic [31:0] ffsum;
        logic [15:0] expv;
        logic [3:0]  na, nb;
        int          w;
        ffsum = 0;
        for (int k = 0; k < 4; k++) begin
            na = (k >= 2) ? a[7:4] : a[3:0];
            nb = (k % 2 == 1) ? b[7:4] : b[3:0];
            if (!dsel || (na != 4'h0 && nb != 4'h0)) begin
                steps.push_back(2'(k));
                ffsum += 32'hFF << (4 * (k / 2) + 4 * (k % 2));
            end
        end
        expv = (!dsel && force_ff) ? ffsum[15:0] : {8'h00, a} * {8'h00, b};
        w = 0;
        while (m_rdy !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        chk("in_ready_before_req", 32'(m_rdy), 1);
        ina = a;
        inb = b;
        set_iv(1'b1);
        tick();
        set_iv(1'b0);
        ina = 8'($urandom);
        inb = 8'($urandom);
        foreach (steps[i]) begin
            chk("calc_busy", 32'(m_busy), 1);
            chk("calc_out_valid", 32'(m_ov), 0);
            chk("calc_in_ready", 32'(m_rdy), 0);
            chk("sub_sel", 32'(m_ss), 32'(steps[i]));
            chk("sub_a", 32'(m_sa), 32'(steps[i][1] ? a[7:4] : a[3:0]));
            chk("sub_b", 32'(m_sb), 32'(steps[i][0] ? b[7:4] : b[3:0]));
            tick();
        end
        chk("done_out_valid", 32'(m_ov), 1);
        chk("done_prod", 32'(m_p), 32'(expv));
        chk("done_in_ready", 32'(m_rdy), 0);
    endtask

    task automatic finish_op();
        set_ordy(1'b1);
        tick();
        chk("after_hs_out_valid", 32'(m_ov), 0);
        chk("after_hs_in_ready", 32'(m_rdy), 1);
        chk("after_hs_busy", 32'(m_busy), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        iv0 = 1'b0; iv1 = 1'b0; ordy0 = 1'b1; ordy1 = 1'b1;
        ina = 8'h00; inb = 8'h00; force_ff = 1'b0; dsel = 1'b0;
        #12;
        chk("rst_in_ready", 32'(rdy0), 1);
        chk("rst_out_valid", 32'(ov0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_prod", 32'(p0), 0);
        chk("rst_sub", {26'h0, ss0, sa0, sb0}, 0);
        chk("rst_sub_skip", {26'h0, ss1, sa1, sb1}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        dsel = 1'b0;
        do_op(8'hB7, 8'h5C);
        chk("b7x5c_prod", 32'(p0), 32'h41C4);
        finish_op();

        ordy0 = 1'b0;
        do_op(8'hB7, 8'h5C);
        for (int i = 0; i < 7; i++) begin
            iv0 = i[0];
            ina = 8'h11;
            inb = 8'h22;
            tick();
            chk("bp_out_valid", 32'(ov0), 1);
            chk("bp_prod", 32'(p0), 32'h41C4);
            chk("bp_in_ready", 32'(rdy0), 0);
        end
        iv0 = 1'b0;
        ordy0 = 1'b1;
        tick();
        chk("bp_release_out_valid", 32'(ov0), 0);
        chk("bp_release_in_ready", 32'(rdy0), 1);
        chk("bp_prod_held", 32'(p0), 32'h41C4);

        dsel = 1'b1;
        do_op(8'h07, 8'h50);
        chk("skip_07x50_prod", 32'(p1), 32'h0230);
        finish_op();
        do_op(8'h00, 8'hFF);
        chk("skip_00xff_prod", 32'(p1), 32'h0000);
        finish_op();
        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 2) == 0) ra[3:0] = 4'h0;
            if ($urandom_range(0, 2) == 0) rb[7:4] = 4'h0;
            do_op(ra, rb);
            finish_op();
        end

        dsel = 1'b0;
        force_ff = 1'b1;
        do_op(8'hFF, 8'hFF);
        chk("wrap_prod", 32'(p0), 32'h1FDF);
        finish_op();
        force_ff = 1'b0;

        ina = 8'hB7;
        inb = 8'h5C;
        iv0 = 1'b1;
        tick();
        iv0 = 1'b0;
        tick();
        tick();
        chk("rst_mid_step", 32'(ss0), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(ov0), 0);
        chk("async_rst_in_ready", 32'(rdy0), 1);
        chk("async_rst_busy", 32'(busy0), 0);
        chk("async_rst_sub", {26'h0, ss0, sa0, sb0}, 0);
        chk("async_rst_prod", 32'(p0), 0);
        #3 rst_n = 1'b1;
        tick();
        chk("post_rst_no_stale", 32'(ov0), 0);
        do_op(8'h12, 8'h34);
        chk("post_rst_prod", 32'(p0), 32'h03A8);
        finish_op();

        ordy0 = 1'b1;
        iv0 = 1'b1;
        ina = 8'($urandom);
        inb = 8'($urandom);
        nres = 0;
        cyc = 0;
        last = -1;
        while (nres < 20 && cyc < 400) begin
            acc_now = rdy0;
            if (ov0) begin
                expq = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
                chk("b2b_prod", 32'(p0), 32'(expq));
                if (last >= 0) chk("b2b_spacing", 32'(cyc - last), 6);
                last = cyc;
                nres++;
            end
            if (acc_now) q.push_back({8'h00, ina} * {8'h00, inb});
            tick();
            cyc++;
            if (acc_now) begin
                ina = 8'($urandom);
                inb = 8'($urandom);
            end
        end
        chk("b2b_result_count", 32'(nres), 20);
        iv0 = 1'b0;
        n = 0;
        while (busy0 !== 1'b0 && n < 12) begin
            tick();
            n++;
        end
        chk("b2b_drain_idle", 32'(rdy0), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul8_seq_ctrl.md
Name: mul8_seq_ctrl

Overview:
- Iterative controller that computes an 8x8 product by time-multiplexing one shared 4x4 sub-multiplier port over up to four cycles.
- Emits one nibble-pair per cycle plus a partial-product select (LL/LH/HL/HH), so an external mux can route each step to the matching approximate 4x4 unit.
- Shift-accumulates the returned 8-bit sub-products into a 16-bit result.
- Serves area-constrained paths where a parallel 8x8 array of four sub-multipliers plus an adder tree is too large.

Parameters:
- SKIP_ZERO, 0: when 1, any step whose a-nibble or b-nibble is zero is skipped (contributes 0 and consumes no cycle).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand request.
- in_ready  out  1  controller can accept operands.
- a  in  8  multiplicand, sampled on the in_valid&&in_ready edge.
- b  in  8  multiplier, sampled on the in_valid&&in_ready edge.
- sub_a  out  4  nibble of the latched a for the current step.
- sub_b  out  4  nibble of the latched b for the current step.
- sub_sel  out  2  current step: 0=LL, 1=LH, 2=HL, 3=HH.
- sub_prod  in  8  combinational 4x4 product of sub_a/sub_b, valid in the same cycle.
- out_valid  out  1  prod is valid.
- out_ready  in  1  consumer accepts prod.
- prod  out  16  accumulated product.
- busy  out  1  high in CALC or DONE.

Behaviour:
- Reset (async assert, rst_n=0): state=IDLE, in_ready=1, out_valid=0, busy=0, prod=0, sub_a=0, sub_b=0, sub_sel=0, accumulator=0, step=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch a/b, clear acc, set step to the first non-skipped step (0 if SKIP_ZERO=0), go to CALC.
  - If SKIP_ZERO=1 and no step survives (a==0 or b==0), go to DONE with acc=0.
- Step operands:
  - LL: sub_a=a[3:0], sub_b=b[3:0], shift 0.
  - LH: sub_a=a[3:0], sub_b=b[7:4], shift 4.
  - HL: sub_a=a[7:4], sub_b=b[3:0], shift 4.
  - HH: sub_a=a[7:4], sub_b=b[7:4], shift 8.
- CALC:
  - Each cycle: acc <= acc + (zero-extended sub_prod << shift), modulo 2^16. Approximate units may return values whose sum exceeds 16 bits; wrap, do not saturate.
  - Advance to the next non-skipped step.
  - After the last step, load prod with the final sum and go to DONE.
  - sub_a/sub_b/sub_sel change only on clock edges and are 0 outside CALC.
- DONE:
  - out_valid=1, prod stable.
  - When out_ready=1: out_valid drops next cycle, go to IDLE.
  - in_ready=0 in DONE, so a new request waits one bubble after the handshake.
- Latency, SKIP_ZERO=0: accept edge T, CALC cycles T+1..T+4, out_valid high from T+5. Throughput is 1 result per 6 cycles when out_ready is held high.
- Latency, SKIP_ZERO=1: out_valid at T+1+N, where N is the number of non-zero nibble pairs (0..4).
- prod holds its last value after the handshake until the next DONE; it is not cleared.
- in_valid during CALC/DONE: ignored, operands not sampled; requester holds until in_ready.
- out_ready asserted outside DONE: no effect.
- Reset mid-CALC or mid-DONE: immediate return to IDLE with all reset values; the partial result is discarded, no out_valid.
- a/b changing after acceptance: no effect, latched copies are used.

Test Plan:
- SKIP_ZERO=0, bench sub-multiplier exact, a=0xB7, b=0x5C accepted at T:
  - sub_sel sequence 0,1,2,3 with sub_prod 0x54, 0x23, 0x84, 0x37.
  - prod=0x41C4 and out_valid=1 at T+5.
- Backpressure: hold out_ready=0 for 7 cycles after out_valid rises -> prod stays 0x41C4, in_ready stays 0, in_valid pulses ignored; out_ready=1 -> out_valid=0 and in_ready=1 on the next edge.
- SKIP_ZERO=1:
  - a=0x07, b=0x50 -> only LH issued (sub_a=7, sub_b=5); prod=0x0230 at T+2.
  - a=0x00, b=0xFF -> no steps issued, prod=0x0000 at T+1.
- Overflow wrap, bench sub-multiplier forced to return 0xFF, a=b=0xFF, SKIP_ZERO=0 -> prod=(0xFF+0xFF0+0xFF0+0xFF00) mod 2^16 = 0x1FDF.
- Reset mid-operation: drop rst_n asynchronously during CALC step 2 -> outputs reach reset values without waiting for a clock edge. After release, a=0x12, b=0x34 -> prod=0x03A8, with no stale result emitted.
- Back-to-back: 20 random operand pairs with in_valid and out_ready held high, checked against a*b with the exact sub-multiplier model; every result exactly 6 cycles apart.
